imem_loader: RTL

Boot-time writer for the core's instruction memory, which the core otherwise only reads. It receives a byte stream over a valid/ready interface, assembles little-endian 32-bit words, writes them to consecutive word addresses and checks an XOR checksum. It holds the core in reset until a load completes with a correct checksum. It sits between the external boot link and the instruction memory write port; it drives the core's active-low reset input.

---
 rtl/imem_loader_if.sv | 10 +
 rtl/imem_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream boot link carrying the instruction image into the loader.
// The master is the external boot source and the slave is the loader.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;

  modport master (output in_valid, output in_byte, input in_ready);
  modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// The loader takes a framed byte stream: a 16-bit little-endian word count,
// then the payload words (little-endian), then an XOR checksum of the payload.
// It writes each word to consecutive word addresses and keeps the core in
// reset until the whole frame has arrived with a matching checksum.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      sif,
  output logic              imem_we,
  output logic [31:0]       imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset_n,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [7:0]  csum_acc;
  logic [7:0]  len_lo;
  logic [15:0] len;

  logic        xfer;
  logic [15:0] frame_len;
  logic [15:0] next_count;

  assign xfer       = sif.in_valid && sif.in_ready;
  assign frame_len  = {sif.in_byte, len_lo};
  assign next_count = word_count + 16'd1;

  // Frame parser: length capture, word assembly, write strobe, checksum verdict
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LEN_LO;
      lane         <= 2'd0;
      word_buf     <= 24'h0;
      csum_acc     <= 8'h0;
      len_lo       <= 8'h0;
      len          <= 16'h0;
      sif.in_ready <= 1'b1;
      imem_we      <= 1'b0;
      imem_waddr   <= BASE_ADDR;
      imem_wdata   <= 32'h0;
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      word_count   <= 16'h0;
    end else begin
      // The write strobe is a single-cycle pulse unless a word completes now
      imem_we <= 1'b0;
      case (state)
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= sif.in_byte;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (xfer) begin
            len <= frame_len;
            if ({16'h0, frame_len} > MAX_WORDS) begin
              state        <= S_ERR;
              sif.in_ready <= 1'b0;
              error        <= 1'b1;
            end else if (frame_len == 16'h0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            csum_acc <= csum_acc ^ sif.in_byte;
            lane     <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= sif.in_byte;
              2'd1: word_buf[15:8]  <= sif.in_byte;
              2'd2: word_buf[23:16] <= sif.in_byte;
              default: begin
                // Lane 3 completes the word; issue its write next cycle
                imem_we    <= 1'b1;
                imem_wdata <= {sif.in_byte, word_buf};
                imem_waddr <= BASE_ADDR + {14'h0, word_count, 2'b00};
                word_count <= next_count;
                if (next_count == len) begin
                  state <= S_CSUM;
                end
              end
            endcase
          end
        end

        S_CSUM: begin
          if (xfer) begin
            sif.in_ready <= 1'b0;
            if (sif.in_byte == csum_acc) begin
              state        <= S_DONE;
              done         <= 1'b1;
              core_reset_n <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        // Terminal states hold their outputs until reset
        S_DONE: state <= S_DONE;
        S_ERR:  state <= S_ERR;
        default: begin
          state        <= S_ERR;
          sif.in_ready <= 1'b0;
          error        <= 1'b1;
          core_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
